// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding imem request, a one-entry buffer
// that holds a fetched word across decode stalls, and wrong-path discard.
module fetch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic             load_use_hazard,
    input  logic             ex_busy,
    output logic             pc_enable,
    output logic [31:0]      f_instr,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        buf_valid;
    logic [31:0] buf_data;

    logic stall;
    logic in_idle;
    logic rsp_ok;
    logic avail;
    logic grant;

    assign stall   = load_use_hazard | ex_busy;
    assign in_idle = (state == IDLE);
    assign rsp_ok  = (state == WAIT) & imem_rvalid & ~redirect_valid;
    assign avail   = buf_valid | rsp_ok;

    // A grant only counts while we are actually requesting (buffer empty).
    assign imem_req = (state == REQ) & ~buf_valid;
    assign grant    = imem_req & imem_gnt;

    assign pc_enable = grant | (redirect_valid & ~in_idle);

    always_comb begin
        f_instr = 32'h0;
        if (buf_valid) begin
            f_instr = buf_data;
        end else if (rsp_ok) begin
            f_instr = imem_rdata;
        end
    end

    assign if_id_enable = redirect_valid | ~stall | in_idle;
    assign if_id_flush  = in_idle | redirect_valid | (~stall & ~avail);
    assign id_ex_flush  = in_idle | redirect_valid | (load_use_hazard & ~ex_busy);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (grant) begin
                    state_next = redirect_valid ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end else if (redirect_valid) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clearing wins over capture, so a redirect during a stall drops the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'h0;
        end else if (redirect_valid || (buf_valid && !stall)) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'h0;
        end else if (rsp_ok && stall) begin
            buf_valid <= 1'b1;
            buf_data  <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (!in_idle && stall && !redirect_valid && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (!in_idle && redirect_valid && (redirect_count != {CNT_W{1'b1}})) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed fetch scenarios with a transaction-level
// reference model compared every cycle, plus hand-computed spot checks.
module tb_fetch_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             imem_req;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic             load_use_hazard;
    logic             ex_busy;
    logic             pc_enable;
    logic [31:0]      f_instr;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: tracks the outstanding fetch as a transaction, not a state.
    bit          m_first = 1'b1;
    bit          m_out   = 1'b0;
    bit          m_wrong = 1'b0;
    logic [31:0] m_buf[$];
    int          m_stall = 0;
    int          m_redir = 0;

    fetch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .load_use_hazard (load_use_hazard),
        .ex_busy         (ex_busy),
        .pc_enable       (pc_enable),
        .f_instr         (f_instr),
        .if_id_enable    (if_id_enable),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .stall_cycles    (stall_cycles),
        .redirect_count  (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        bit          s;
        bit          ok;
        bit          e_req;
        logic [31:0] e_instr;
        if (!reset) begin
            m_first = 1'b1;
            m_out   = 1'b0;
            m_wrong = 1'b0;
            m_buf.delete();
            m_stall = 0;
            m_redir = 0;
        end
        s       = load_use_hazard | ex_busy;
        ok      = m_out & !m_wrong & imem_rvalid & !redirect_valid;
        e_req   = !m_first & !m_out & (m_buf.size() == 0);
        e_instr = (m_buf.size() > 0) ? m_buf[0] : (ok ? imem_rdata : 32'h0);

        check_output("cmp imem_req", 32'(imem_req), 32'(e_req));
        check_output("cmp pc_enable", 32'(pc_enable),
                     32'((e_req & imem_gnt) | (redirect_valid & !m_first)));
        check_output("cmp f_instr", f_instr, e_instr);
        check_output("cmp if_id_enable", 32'(if_id_enable), 32'(redirect_valid | !s | m_first));
        check_output("cmp if_id_flush", 32'(if_id_flush),
                     32'(m_first | redirect_valid | (!s & !((m_buf.size() > 0) | ok))));
        check_output("cmp id_ex_flush", 32'(id_ex_flush),
                     32'(m_first | redirect_valid | (load_use_hazard & !ex_busy)));
        check_output("cmp stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check_output("cmp redirect_count", 32'(redirect_count), 32'(m_redir));

        if (reset) begin
            if (m_first) begin
                m_first = 1'b0;
            end else begin
                if (e_req && imem_gnt) begin
                    m_out   = 1'b1;
                    m_wrong = redirect_valid;
                end else if (m_out && imem_rvalid) begin
                    m_out   = 1'b0;
                    m_wrong = 1'b0;
                end else if (m_out && redirect_valid) begin
                    m_wrong = 1'b1;
                end
                if (redirect_valid || (m_buf.size() > 0 && !s)) begin
                    m_buf.delete();
                end else if (ok && s) begin
                    m_buf.push_back(imem_rdata);
                end
                if (s && !redirect_valid && m_stall < CNT_MAX) m_stall++;
                if (redirect_valid && m_redir < CNT_MAX) m_redir++;
            end
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic gnt, input logic rv,
                                  input logic [31:0] data, input logic redir,
                                  input logic luh, input logic exb);
        reset           = rst;
        imem_gnt        = gnt;
        imem_rvalid     = rv;
        imem_rdata      = data;
        redirect_valid  = redir;
        load_use_hazard = luh;
        ex_busy         = exb;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; load_use_hazard = 1'b0; ex_busy = 1'b0;
        step();

        $display("[TB] reset values with busy inputs");
        apply_stimulus(0, 1, 1, 32'hFFFF_FFFF, 1, 1, 1);
        check_output("rst imem_req", 32'(imem_req), 32'h0);
        check_output("rst pc_enable", 32'(pc_enable), 32'h0);
        check_output("rst f_instr", f_instr, 32'h0);
        check_output("rst if_id_enable", 32'(if_id_enable), 32'h1);
        check_output("rst if_id_flush", 32'(if_id_flush), 32'h1);
        check_output("rst id_ex_flush", 32'(id_ex_flush), 32'h1);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0, 0, 0); step();

        $display("[TB] zero-wait fetch");
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("c1 pc_enable", 32'(pc_enable), 32'h0);
        check_output("c1 if_id_flush", 32'(if_id_flush), 32'h1);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("c2 imem_req", 32'(imem_req), 32'h1);
        check_output("c2 pc_enable", 32'(pc_enable), 32'h1);
        step();
        apply_stimulus(1, 1, 1, 32'h0000_0013, 0, 0, 0);
        check_output("c3 f_instr", f_instr, 32'h0000_0013);
        check_output("c3 if_id_flush", 32'(if_id_flush), 32'h0);
        check_output("c3 pc_enable", 32'(pc_enable), 32'h0);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("c4 pc_enable", 32'(pc_enable), 32'h1);
        step();
        apply_stimulus(1, 1, 1, 32'h0050_0093, 0, 0, 0);
        check_output("c5 f_instr", f_instr, 32'h0050_0093);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0); step();

        $display("[TB] load-use stall with response");
        apply_stimulus(1, 1, 1, 32'h00A0_0113, 0, 1, 0);
        check_output("luh1 if_id_enable", 32'(if_id_enable), 32'h0);
        check_output("luh1 id_ex_flush", 32'(id_ex_flush), 32'h1);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 1, 0);
        check_output("luh2 imem_req", 32'(imem_req), 32'h0);
        check_output("luh2 f_instr", f_instr, 32'h00A0_0113);
        check_output("luh2 id_ex_flush", 32'(id_ex_flush), 32'h1);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("luh3 f_instr", f_instr, 32'h00A0_0113);
        check_output("luh3 if_id_enable", 32'(if_id_enable), 32'h1);
        check_output("luh3 if_id_flush", 32'(if_id_flush), 32'h0);
        step();
        check_output("luh stall_cycles", 32'(stall_cycles), 32'd2);

        $display("[TB] redirect in grant cycle");
        apply_stimulus(1, 1, 0, 32'h0, 1, 0, 0);
        check_output("rd pc_enable", 32'(pc_enable), 32'h1);
        check_output("rd if_id_flush", 32'(if_id_flush), 32'h1);
        step();
        check_output("rd redirect_count", 32'(redirect_count), 32'd1);
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("discard imem_req", 32'(imem_req), 32'h0);
        step();
        apply_stimulus(1, 0, 0, 32'h0, 0, 0, 0); step();
        apply_stimulus(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check_output("discard f_instr", f_instr, 32'h0);
        check_output("discard if_id_flush", 32'(if_id_flush), 32'h1);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("after discard imem_req", 32'(imem_req), 32'h1);
        step();

        $display("[TB] ex_busy with full buffer");
        apply_stimulus(1, 1, 1, 32'h00B0_0193, 0, 0, 1); step();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 1, 0, 32'h0, 0, 0, 1);
            check_output("busy imem_req", 32'(imem_req), 32'h0);
            check_output("busy id_ex_flush", 32'(id_ex_flush), 32'h0);
            check_output("busy if_id_enable", 32'(if_id_enable), 32'h0);
            step();
        end
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("busy release f_instr", f_instr, 32'h00B0_0193);
        step();
        check_output("busy stall_cycles", 32'(stall_cycles), 32'd7);
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0); step();
        apply_stimulus(1, 0, 0, 32'h0, 0, 0, 0); step();

        $display("[TB] reset while waiting, stale response");
        apply_stimulus(0, 0, 0, 32'h0, 0, 0, 0);
        check_output("mid rst stall_cycles", 32'(stall_cycles), 32'h0);
        check_output("mid rst redirect_count", 32'(redirect_count), 32'h0);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0, 0, 0); step();
        apply_stimulus(1, 0, 1, 32'hBAD0_BAD0, 0, 0, 0);
        check_output("stale f_instr", f_instr, 32'h0);
        check_output("stale pc_enable", 32'(pc_enable), 32'h0);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("resume pc_enable", 32'(pc_enable), 32'h1);
        step();
        apply_stimulus(1, 1, 1, 32'h00C0_0213, 0, 0, 0);
        check_output("resume f_instr", f_instr, 32'h00C0_0213);
        step();

        $display("[TB] redirect with rvalid, redirect with stall");
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0); step();
        apply_stimulus(1, 1, 1, 32'h1111_1111, 1, 0, 0);
        check_output("rdrv f_instr", f_instr, 32'h0);
        check_output("rdrv if_id_flush", 32'(if_id_flush), 32'h1);
        step();
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        check_output("rdrv next imem_req", 32'(imem_req), 32'h1);
        step();
        apply_stimulus(1, 1, 1, 32'h00D0_0293, 0, 1, 0); step();
        apply_stimulus(1, 1, 0, 32'h0, 1, 1, 0);
        check_output("rdst if_id_flush", 32'(if_id_flush), 32'h1);
        check_output("rdst id_ex_flush", 32'(id_ex_flush), 32'h1);
        check_output("rdst if_id_enable", 32'(if_id_enable), 32'h1);
        step();

        $display("[TB] counter saturation");
        apply_stimulus(1, 0, 0, 32'h0, 0, 0, 1);
        check_output("rdst buffer cleared", f_instr, 32'h0);
        check_output("rdst imem_req", 32'(imem_req), 32'h1);
        step();
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(1, 0, 0, 32'h0, 0, 0, 1); step();
        end
        check_output("sat stall_cycles", 32'(stall_cycles), 32'd15);
        check_output("sat redirect_count", 32'(redirect_count), 32'd2);
        apply_stimulus(1, 0, 0, 32'h0, 0, 0, 0); step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the five-stage pipeline. It issues instruction-memory requests and tracks the single outstanding fetch. It holds one fetched instruction in a one-entry buffer while decode is stalled. It generates the PC enable, the IF/ID enable and flush, and the ID/EX flush, and it discards wrong-path responses after a branch or jump redirect resolved in EX.

## Interface
Parameters
- CNT_W, 32, width of the saturating performance counters

Ports
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- imem_req  out  1  fetch request for the current PC
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; never in the same cycle as its grant
- imem_rdata  in  32  response instruction word
- redirect_valid  in  1  EX resolved a taken branch or jump; the PC mux selects the target
- load_use_hazard  in  1  decode needs a one-cycle bubble into EX
- ex_busy  in  1  multi-cycle EX unit busy; ID and EX hold
- pc_enable  out  1  PC register load enable
- f_instr  out  32  instruction presented to the IF/ID register
- if_id_enable  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a zero bubble; has priority over the enable
- id_ex_flush  out  1  ID/EX loads a bubble
- stall_cycles  out  CNT_W  saturating count of stall cycles
- redirect_count  out  CNT_W  saturating count of redirect cycles

## Operation
- Internal signals:
  - stall = load_use_hazard | ex_busy.
  - rsp_ok = (state==WAIT) & imem_rvalid & !redirect_valid.
  - avail = buf_valid | rsp_ok.
- States: IDLE, REQ, WAIT, DISCARD.
  - IDLE: one cycle after reset release; always goes to REQ. redirect_valid is ignored in IDLE.
  - REQ: imem_req = !buf_valid.
    - Grant without redirect: go to WAIT.
    - Grant with redirect: go to DISCARD, because the granted request is wrong-path.
    - No grant: stay in REQ.
  - WAIT: imem_req = 0.
    - rvalid: go to REQ. The response is dropped if redirect_valid is high.
    - No rvalid and redirect: go to DISCARD.
  - DISCARD: imem_req = 0. rvalid means the response is dropped; go to REQ. Redirects in DISCARD keep the state.
- At most one request is outstanding. A new request is issued only when the buffer is empty.
- pc_enable = (imem_req & imem_gnt) | (redirect_valid & state!=IDLE).
- f_instr:
  - buf_valid: buffered word.
  - rsp_ok: imem_rdata.
  - Otherwise 32'h0.
- IF/ID control:
  - if_id_enable = redirect_valid | !stall | IDLE.
  - if_id_flush = IDLE | redirect_valid | (!stall & !avail).
- id_ex_flush = IDLE | redirect_valid | (load_use_hazard & !ex_busy).
- Buffer:
  - Captures imem_rdata when rsp_ok & stall.
  - Cleared when (buf_valid & !stall) or redirect_valid. Clearing has priority.
  - Invariant: a response never arrives while buf_valid=1.
- Counters, both saturating at all ones and never wrapping:
  - stall_cycles increments when state!=IDLE & stall & !redirect_valid.
  - redirect_count increments when state!=IDLE & redirect_valid.

## Timing
- While reset=0, and in the IDLE cycle:
  - State IDLE; buf_valid=0; buffer 0; counters 0.
  - imem_req=0, pc_enable=0, f_instr=0.
  - if_id_enable=1, if_id_flush=1, id_ex_flush=1.
- Reset asserted mid-fetch abandons any outstanding request. A late rvalid arriving in IDLE or REQ is ignored.
- All outputs except the counters are combinational from state and inputs. The counters and buffer update on the rising edge.
- Zero-wait memory (gnt in cycle n, rvalid in n+1): sustained throughput is one instruction every 2 cycles. The first instruction loads into IF/ID at the edge ending cycle 3 after reset release.
- Stall arriving with a response: the word is buffered. It is presented in the first cycle with stall=0, and IF/ID loads it at that edge.
- Redirect together with rvalid in WAIT: the response is dropped, IF/ID is flushed, and REQ is entered next cycle.
- Simultaneous redirect and stall: the redirect wins. IF/ID is flushed, ID/EX is flushed, and the buffer is cleared.

## Test plan
- Release reset with imem_gnt=1 and 1-cycle rvalid data 0x00000013, 0x00500093: f_instr loads into IF/ID at the end of cycles 3 and 5; pc_enable pulses in cycles 2 and 4.
- Set load_use_hazard=1 for 2 cycles coincident with rvalid (data 0x00A00113): the buffer holds 0x00A00113; imem_req=0; if_id_enable=0; id_ex_flush=1 for 2 cycles; IF/ID loads the word after the stall; stall_cycles=2.
- Assert redirect_valid in the grant cycle and rvalid 3 cycles later: the state goes to DISCARD; the response is dropped with if_id_flush=1; the next request follows with pc_enable=1 at the redirect; redirect_count=1.
- Assert ex_busy for 5 cycles with a full buffer: no request is issued, id_ex_flush=0, and IF/ID holds throughout.
- Drive reset low while in WAIT, then high, then a stale rvalid in cycle 1: the response is ignored, all outputs are at their reset values, and normal fetch resumes.
- Force stall_cycles to all ones via a long stall (CNT_W=4, 20 stall cycles): the counter saturates at 15.
